cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 90 +++++++++
 rtl/cpu_reg_file.sv | 39 +++
 rtl/cpu.sv | 213 +++++++++++++++++++++
 tb/tb_cpu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the single-cycle RV32I core:
// opcodes, funct3/funct7 codes, ALU operations and the decoded control bundle.
package cpu_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    // ALU funct3 codes (shared by OP and OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Word-size load/store and JALR funct3
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 variants
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    // Decoded control for one instruction; all-zero means NOP.
    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    load;
        logic    branch;
        logic    jal;
        logic    jalr;
        logic    a_pc;
        logic    b_imm;
        alu_op_e alu_op;
    } ctrl_t;

    // Branch condition for a conditional branch with the given funct3.
    function automatic logic branch_taken(input logic [2:0]  funct3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic eq;
        logic lt;
        logic ltu;
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        case (funct3)
            F3_BEQ:  return eq;
            F3_BNE:  return !eq;
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            F3_BLTU: return ltu;
            F3_BGEU: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// x0 reads as zero and ignores writes; a same-cycle read returns the old value.
module reg_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,   // active-high synchronous reset
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] registers [0:31];

    // Clear every register on reset, otherwise write one register per clock.
    // NOTE: the array is reset because software relies on all registers being
    // zero after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 32; i++) begin
                // NOTE: non-blocking so every read this cycle sees the old value.
                registers[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            registers[waddr] <= wdata;
        end
    end

    // Combinational read ports; x0 is forced to zero.
    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
        rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I core (CPI = 1). Instruction ROM and data RAM are external;
// both are read combinationally and the RAM writes on the edge ending an SW.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,      // active-high synchronous reset despite its name
    output logic [31:0] rom_addr,
    input  logic [31:0] instruction,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_sig,
    input  logic [31:0] mem_rd_data
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // Sign-extended immediates for every format
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] pc_plus4;
    logic [31:0] wb_data;
    logic        rf_we;
    logic        take_branch;

    // Decode: pick control and immediate; unsupported encodings fall out as NOP.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch forms.
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        imm         = imm_i;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_we = 1'b1;
                ctrl.b_imm  = 1'b1;
                ctrl.alu_op = ALU_PASS_B;
                imm         = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.reg_we = 1'b1;
                ctrl.a_pc   = 1'b1;
                ctrl.b_imm  = 1'b1;
                imm         = imm_u;
            end
            OPC_JAL: begin
                ctrl.reg_we = 1'b1;
                ctrl.jal    = 1'b1;
                imm         = imm_j;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.jalr   = 1'b1;
                    ctrl.b_imm  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                imm         = imm_b;
                ctrl.branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.load   = 1'b1;
                    ctrl.b_imm  = 1'b1;
                end
            end
            OPC_STORE: begin
                imm = imm_s;
                if (funct3 == F3_WORD) begin
                    ctrl.mem_we = 1'b1;
                    ctrl.b_imm  = 1'b1;
                end
            end
            OPC_IMM: begin
                ctrl.reg_we = 1'b1;
                ctrl.b_imm  = 1'b1;
                case (funct3)
                    F3_ADD:  ctrl.alu_op = ALU_ADD;
                    F3_SLT:  ctrl.alu_op = ALU_SLT;
                    F3_SLTU: ctrl.alu_op = ALU_SLTU;
                    F3_XOR:  ctrl.alu_op = ALU_XOR;
                    F3_OR:   ctrl.alu_op = ALU_OR;
                    F3_AND:  ctrl.alu_op = ALU_AND;
                    F3_SLL: begin
                        if (funct7 == F7_BASE) ctrl.alu_op = ALU_SLL;
                        else                   ctrl.reg_we = 1'b0;
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE)     ctrl.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                        else                       ctrl.reg_we = 1'b0;
                    end
                    default: ctrl.reg_we = 1'b0;
                endcase
            end
            OPC_REG: begin
                ctrl.reg_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  ctrl.alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  ctrl.alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}:  ctrl.alu_op = ALU_SLL;
                    {F7_BASE, F3_SLT}:  ctrl.alu_op = ALU_SLT;
                    {F7_BASE, F3_SLTU}: ctrl.alu_op = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  ctrl.alu_op = ALU_XOR;
                    {F7_BASE, F3_SR}:   ctrl.alu_op = ALU_SRL;
                    {F7_ALT,  F3_SR}:   ctrl.alu_op = ALU_SRA;
                    {F7_BASE, F3_OR}:   ctrl.alu_op = ALU_OR;
                    {F7_BASE, F3_AND}:  ctrl.alu_op = ALU_AND;
                    default:            ctrl.reg_we = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // ALU: operand muxes and the 32-bit wrap-around operation.
    always_comb begin
        alu_a = ctrl.a_pc  ? pc_q : rs1_data;
        alu_b = ctrl.b_imm ? imm  : rs2_data;
        case (ctrl.alu_op)
            ALU_ADD:    alu_y = alu_a + alu_b;
            ALU_SUB:    alu_y = alu_a - alu_b;
            ALU_SLL:    alu_y = alu_a << alu_b[4:0];
            ALU_SLT:    alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_y = {31'd0, alu_a < alu_b};
            ALU_XOR:    alu_y = alu_a ^ alu_b;
            ALU_SRL:    alu_y = alu_a >> alu_b[4:0];
            ALU_SRA:    alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:     alu_y = alu_a | alu_b;
            ALU_AND:    alu_y = alu_a & alu_b;
            ALU_PASS_B: alu_y = alu_b;
            default:    alu_y = alu_a + alu_b;
        endcase
    end

    // Next PC, writeback selection and side-effect gating during reset.
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        take_branch = ctrl.branch && branch_taken(funct3, rs1_data, rs2_data);
        if (reset_n)                      pc_d = RESET_PC;
        else if (ctrl.jal || take_branch) pc_d = pc_q + imm;
        else if (ctrl.jalr)               pc_d = {alu_y[31:1], 1'b0};
        else                              pc_d = pc_plus4;

        if (ctrl.jal || ctrl.jalr) wb_data = pc_plus4;
        else if (ctrl.load)        wb_data = mem_rd_data;
        else                       wb_data = alu_y;

        rf_we      = ctrl.reg_we && !reset_n;
        mem_wr_sig = ctrl.mem_we && !reset_n;
    end

    assign rom_addr    = pc_q;
    assign mem_addr    = alu_y;
    assign mem_wr_data = rs2_data;

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset_n) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    reg_file reg_file_inst (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle RV32I core: reset, an instruction mix,
// Fibonacci, recursive sum, and a mid-program reset.
module tb_cpu;

    localparam int OP_IMM  = 7'b0010011;
    localparam int OP_REG  = 7'b0110011;
    localparam int OP_LOAD = 7'b0000011;
    localparam int OP_JALR = 7'b1100111;
    localparam int OP_LUI  = 7'b0110111;
    localparam int OP_AUIPC = 7'b0010111;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_sig;
    logic [31:0] mem_rd_data;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:127];
    int          rst_wr_cnt = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rom_addr   (rom_addr),
        .instruction(instruction),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_sig (mem_wr_sig),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    assign instruction = rom[rom_addr[7:2]];
    assign mem_rd_data = ram[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_wr_sig) begin
            ram[mem_addr[8:2]] <= mem_wr_data;
            if (reset_n) rst_wr_cnt <= rst_wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int idx);
        return dut.reg_file_inst.registers[idx];
    endfunction

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        logic [31:0] v, a, f, d, o;
        v = imm; a = rs1; f = f3; d = rd; o = op;
        return {v[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        logic [31:0] v, d, o;
        v = imm20; d = rd; o = op;
        return {v[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = NOP_WORD;
    endtask

    // Hold reset for two edges, check it suppresses writes, then release.
    task automatic do_reset(input string tag);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_wr_in_rst"}, {31'd0, mem_wr_sig}, 32'd0);
        reset_n = 1'b0;
        check({tag, "_pc_after_rst"}, rom_addr, 32'd0);
    endtask

    task automatic run_until(input logic [31:0] target, input int budget, input string tag);
        int n = 0;
        while (rom_addr !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, rom_addr, target);
    endtask

    task automatic load_recursive();
        clear_rom();
        rom[0]  = enc_i(256, 0, 0, 2, OP_IMM);    // sp = 256
        rom[1]  = enc_i(10, 0, 0, 10, OP_IMM);    // a0 = 10
        rom[2]  = enc_j(12, 1);                   // jal ra, sum (20)
        rom[3]  = enc_i(0, 10, 0, 29, OP_IMM);    // x29 = a0
        rom[4]  = enc_j(0, 0);                    // halt at 16
        rom[5]  = enc_b(8, 0, 10, 1);             // sum: bne a0, x0, +8
        rom[6]  = enc_i(0, 1, 0, 0, OP_JALR);     // ret (a0 == 0)
        rom[7]  = enc_i(-8, 2, 0, 2, OP_IMM);     // sp -= 8
        rom[8]  = enc_s(0, 1, 2, 2);              // sw ra, 0(sp)
        rom[9]  = enc_s(4, 10, 2, 2);             // sw a0, 4(sp)
        rom[10] = enc_i(-1, 10, 0, 10, OP_IMM);   // a0 -= 1
        rom[11] = enc_j(-24, 1);                  // jal ra, sum
        rom[12] = enc_i(4, 2, 2, 5, OP_LOAD);     // lw x5, 4(sp)
        rom[13] = enc_i(0, 2, 2, 1, OP_LOAD);     // lw ra, 0(sp)
        rom[14] = enc_r(0, 5, 10, 0, 10);         // a0 = a0 + x5
        rom[15] = enc_i(8, 2, 0, 2, OP_IMM);      // sp += 8
        rom[16] = enc_i(0, 1, 0, 0, OP_JALR);     // ret
    endtask

    int exp_pc [22] = '{0, 4, 8, 12, 16, 20, 28, 32, 36, 40, 48,
                        52, 60, 64, 68, 72, 76, 80, 84, 88, 92, 92};

    initial begin
        int nonzero;

        // ---------------- Instruction mix ----------------
        clear_rom();
        rom[0]  = enc_i(-1, 0, 0, 1, OP_IMM);      // addi x1, x0, -1
        rom[1]  = enc_i(5, 0, 0, 0, OP_IMM);       // addi x0, x0, 5
        rom[2]  = enc_s(8, 1, 0, 2);               // sw x1, 8(x0)
        rom[3]  = enc_i(8, 0, 2, 2, OP_LOAD);      // lw x2, 8(x0)
        rom[4]  = enc_i(1, 0, 0, 2, OP_IMM);       // addi x2, x0, 1
        rom[5]  = enc_b(8, 2, 1, 4);               // blt x1, x2, +8 (taken)
        rom[6]  = enc_i(99, 0, 0, 6, OP_IMM);      // skipped
        rom[7]  = enc_b(8, 2, 1, 6);               // bltu x1, x2, +8 (not taken)
        rom[8]  = enc_r(0, 2, 1, 2, 4);            // slt x4, x1, x2
        rom[9]  = enc_r(0, 2, 1, 3, 5);            // sltu x5, x1, x2
        rom[10] = enc_j(8, 7);                     // jal x7, +8
        rom[11] = enc_i(77, 0, 0, 6, OP_IMM);      // skipped
        rom[12] = enc_i(61, 0, 0, 8, OP_IMM);      // addi x8, x0, 61
        rom[13] = enc_i(0, 8, 0, 8, OP_JALR);      // jalr x8, 0(x8) -> 60
        rom[14] = enc_i(55, 0, 0, 6, OP_IMM);      // skipped
        rom[15] = enc_u(32'h12345, 9, OP_LUI);     // lui x9
        rom[16] = enc_u(1, 10, OP_AUIPC);          // auipc x10, 1
        rom[17] = enc_i(32'h404, 1, 5, 11, OP_IMM); // srai x11, x1, 4
        rom[18] = enc_i(28, 1, 5, 12, OP_IMM);     // srli x12, x1, 28
        rom[19] = enc_r(32, 1, 2, 0, 13);          // sub x13, x2, x1
        rom[20] = 32'h0000_000F;                   // fence -> NOP
        rom[21] = 32'h0000_0073;                   // ecall -> NOP
        rom[22] = enc_s(12, 1, 0, 0);              // sb -> NOP
        rom[23] = enc_j(0, 0);                     // halt at 92

        do_reset("init");
        check("init_x1_zero", rf(1), 32'd0);

        for (int k = 0; k < 22; k++) begin
            check($sformatf("mix_pc%0d", k), rom_addr, exp_pc[k]);
            check($sformatf("mix_wr%0d", k), {31'd0, mem_wr_sig},
                  (exp_pc[k] == 8) ? 32'd1 : 32'd0);
            if (exp_pc[k] == 8) begin
                check("sw_addr", mem_addr, 32'd8);
                check("sw_data", mem_wr_data, 32'hFFFF_FFFF);
            end
            if (k == 2) check("x0_after_addi", rf(0), 32'd0);
            if (k == 4) begin
                check("lw_x2", rf(2), 32'hFFFF_FFFF);
                check("ram_word2", ram[2], 32'hFFFF_FFFF);
            end
            @(negedge clk);
        end
        check("x0",  rf(0),  32'd0);
        check("x1",  rf(1),  32'hFFFF_FFFF);
        check("x2",  rf(2),  32'd1);
        check("slt", rf(4),  32'd1);
        check("sltu", rf(5), 32'd0);
        check("skipped_x6", rf(6), 32'd0);
        check("jal_link", rf(7), 32'd44);
        check("jalr_link", rf(8), 32'd56);
        check("lui", rf(9), 32'h1234_5000);
        check("auipc", rf(10), 32'h0000_1040);
        check("srai", rf(11), 32'hFFFF_FFFF);
        check("srli", rf(12), 32'h0000_000F);
        check("sub", rf(13), 32'd2);
        check("sb_nop_ram", ram[3] === 32'hFFFF_FFFF ? 32'd1 : 32'd0, 32'd0);

        // ---------------- Iterative Fibonacci ----------------
        clear_rom();
        rom[0] = enc_i(0, 0, 0, 1, OP_IMM);        // a = 0
        rom[1] = enc_i(1, 0, 0, 2, OP_IMM);        // b = 1
        rom[2] = enc_i(9, 0, 0, 4, OP_IMM);        // n = 9
        rom[3] = enc_r(0, 2, 1, 0, 3);             // x3 = a + b
        rom[4] = enc_i(0, 2, 0, 1, OP_IMM);        // a = b
        rom[5] = enc_i(0, 3, 0, 2, OP_IMM);        // b = x3
        rom[6] = enc_i(-1, 4, 0, 4, OP_IMM);       // n--
        rom[7] = enc_b(-16, 0, 4, 1);              // bne n, x0, loop
        rom[8] = enc_j(0, 0);                      // halt at 32
        do_reset("fib");
        run_until(32'd32, 500, "fib_halt");
        check("fib_x3", rf(3), 32'd55);
        check("fib_x4", rf(4), 32'd0);

        // ---------------- Recursive sum ----------------
        load_recursive();
        do_reset("rec");
        run_until(32'd16, 500, "rec_halt");
        check("rec_x29", rf(29), 32'd55);
        check("rec_sp", rf(2), 32'd256);

        // ---------------- Mid-program reset ----------------
        do_reset("mid");
        run_until(32'd32, 100, "mid_at_sw");
        check("mid_sp_before", rf(2), 32'd248);
        reset_n = 1'b1;
        #1;
        check("mid_wr_in_rst", {31'd0, mem_wr_sig}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        check("mid_pc_zero", rom_addr, 32'd0);
        nonzero = 0;
        for (int i = 0; i < 32; i++) if (rf(i) !== 32'd0) nonzero++;
        check("mid_regs_zero", nonzero, 32'd0);
        check("mid_ram_wr_in_rst", rst_wr_cnt, 32'd0);
        run_until(32'd16, 500, "mid_rerun_halt");
        check("mid_rerun_x29", rf(29), 32'd55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
